// File: rtl/bus_transfer_arbiter.sv
// bus_transfer_arbiter: round-robin arbiter that grants one requester at a time
// and performs a single register-to-register bus transfer for it.
// One transfer takes three cycles: grant, then enables, then the done pulse.
//
// Optional feature macro: BUS_ARB_R0_PROTECT_EN
//   defined   : writes to register 0 are suppressed and flagged on err.
//   undefined : register 0 is writable like any other; err stays 0.
//
// Ports:
//   clock      - single clock, all state on posedge
//   clear      - asynchronous active-high reset
//   req        - per-requester transfer request (level)
//   src_sel    - packed source register index, requester i at [i*SEL_WIDTH +: SEL_WIDTH]
//   dst_sel    - packed destination register index, same packing
//   gnt        - one-hot grant to the current owner
//   bus_src_en - one-hot source register bus drive enable
//   reg_enable - one-hot destination register load enable
//   done       - one-cycle completion pulse to the owner
//   busy       - transfer in progress
//   err        - one-cycle protection violation pulse
module bus_transfer_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned SEL_WIDTH = 4
) (
    input  logic                         clock,
    input  logic                         clear,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*SEL_WIDTH-1:0] src_sel,
    input  logic [NUM_REQ*SEL_WIDTH-1:0] dst_sel,
    output logic [NUM_REQ-1:0]           gnt,
    output logic [(2**SEL_WIDTH)-1:0]    bus_src_en,
    output logic [(2**SEL_WIDTH)-1:0]    reg_enable,
    output logic [NUM_REQ-1:0]           done,
    output logic                         busy,
    output logic                         err
);

    localparam int unsigned NUM_REGS = 2**SEL_WIDTH;
    localparam int unsigned IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [IDX_W-1:0]     ptr_q, ptr_nxt;
    logic [IDX_W-1:0]     owner_q, owner_nxt;
    logic [SEL_WIDTH-1:0] src_q, src_nxt;
    logic [SEL_WIDTH-1:0] dst_q, dst_nxt;

    logic [NUM_REQ-1:0]   gnt_nxt;
    logic [NUM_REGS-1:0]  bus_src_en_nxt;
    logic [NUM_REGS-1:0]  reg_enable_nxt;
    logic [NUM_REQ-1:0]   done_nxt;
    logic                 busy_nxt;
    logic                 err_nxt;

    logic [SEL_WIDTH-1:0] src_arr [NUM_REQ];
    logic [SEL_WIDTH-1:0] dst_arr [NUM_REQ];

    logic                 found;
    logic [IDX_W-1:0]     win_idx;
    logic [IDX_W-1:0]     cand_idx;
    int unsigned          cand;

    // Unpack per-requester register indices
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign src_arr[g] = src_sel[g*SEL_WIDTH +: SEL_WIDTH];
        assign dst_arr[g] = dst_sel[g*SEL_WIDTH +: SEL_WIDTH];
    end

    // Round-robin search: first set req at or above ptr, wrapping
    always_comb begin
        found    = 1'b0;
        win_idx  = '0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand     = (32'(ptr_q) + k) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!found && req[cand_idx]) begin
                found   = 1'b1;
                win_idx = cand_idx;
            end
        end
    end

    // State register
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|req) state_nxt = XFER;
            XFER:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: next values for the output and context flops
    always_comb begin
        gnt_nxt        = '0;
        bus_src_en_nxt = '0;
        reg_enable_nxt = '0;
        done_nxt       = '0;
        busy_nxt       = 1'b0;
        err_nxt        = 1'b0;
        ptr_nxt        = ptr_q;
        owner_nxt      = owner_q;
        src_nxt        = src_q;
        dst_nxt        = dst_q;
        case (state)
            IDLE: begin
                if (|req) begin
                    owner_nxt = win_idx;
                    src_nxt   = src_arr[win_idx];
                    dst_nxt   = dst_arr[win_idx];
                    gnt_nxt   = NUM_REQ'(1) << win_idx;
                    busy_nxt  = 1'b1;
                end
            end
            XFER: begin
                gnt_nxt        = gnt;
                busy_nxt       = 1'b1;
                bus_src_en_nxt = NUM_REGS'(1) << src_q;
`ifdef BUS_ARB_R0_PROTECT_EN
                // Register 0 is read-only: drop the load, flag the attempt
                if (dst_q == '0) begin
                    err_nxt = 1'b1;
                end else begin
                    reg_enable_nxt = NUM_REGS'(1) << dst_q;
                end
`else
                reg_enable_nxt = NUM_REGS'(1) << dst_q;
`endif
            end
            DONE: begin
                // busy stays up through the done cycle so a transfer shows 3 busy cycles
                busy_nxt = 1'b1;
                done_nxt = NUM_REQ'(1) << owner_q;
                ptr_nxt  = (32'(owner_q) == NUM_REQ - 1) ? '0 : owner_q + 1'b1;
            end
            default: ;
        endcase
    end

    // Output and transfer-context registers
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            gnt        <= '0;
            bus_src_en <= '0;
            reg_enable <= '0;
            done       <= '0;
            busy       <= 1'b0;
            err        <= 1'b0;
            ptr_q      <= '0;
            owner_q    <= '0;
            src_q      <= '0;
            dst_q      <= '0;
        end else begin
            gnt        <= gnt_nxt;
            bus_src_en <= bus_src_en_nxt;
            reg_enable <= reg_enable_nxt;
            done       <= done_nxt;
            busy       <= busy_nxt;
            err        <= err_nxt;
            ptr_q      <= ptr_nxt;
            owner_q    <= owner_nxt;
            src_q      <= src_nxt;
            dst_q      <= dst_nxt;
        end
    end

endmodule

// File: tb/tb_bus_transfer_arbiter.sv
// tb_bus_transfer_arbiter: directed scoreboard bench for bus_transfer_arbiter
// with default parameters (4 requesters, 16 registers).
module tb_bus_transfer_arbiter;

    logic        clock;
    logic        clear;
    logic [3:0]  req;
    logic [15:0] src_sel;
    logic [15:0] dst_sel;
    logic [3:0]  gnt;
    logic [15:0] bus_src_en;
    logic [15:0] reg_enable;
    logic [3:0]  done;
    logic        busy;
    logic        err;

    typedef struct {
        logic [3:0]  gnt;
        logic [15:0] src_en;
        logic [15:0] reg_en;
        logic [3:0]  done;
        logic        busy;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    bus_transfer_arbiter dut (
        .clock      (clock),
        .clear      (clear),
        .req        (req),
        .src_sel    (src_sel),
        .dst_sel    (dst_sel),
        .gnt        (gnt),
        .bus_src_en (bus_src_en),
        .reg_enable (reg_enable),
        .done       (done),
        .busy       (busy),
        .err        (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [15:0] pack(input logic [3:0] a0, input logic [3:0] a1,
                                         input logic [3:0] a2, input logic [3:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    task automatic cmp(input string tag, input logic [15:0] act, input logic [15:0] expv);
        checks++;
        assert (act === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, act, expv);
        end
    endtask

    task automatic push(input logic [3:0] g, input logic [15:0] s, input logic [15:0] r,
                        input logic [3:0] d, input logic b, input logic e);
        exp_t x;
        x.gnt    = g;
        x.src_en = s;
        x.reg_en = r;
        x.done   = d;
        x.busy   = b;
        x.err    = e;
        sb.push_back(x);
    endtask

    task automatic compare_outputs(input string tag, input exp_t x);
        cmp({tag, ".gnt"},        16'(gnt),  16'(x.gnt));
        cmp({tag, ".bus_src_en"}, bus_src_en, x.src_en);
        cmp({tag, ".reg_enable"}, reg_enable, x.reg_en);
        cmp({tag, ".done"},       16'(done), 16'(x.done));
        cmp({tag, ".busy"},       16'(busy), 16'(x.busy));
        cmp({tag, ".err"},        16'(err),  16'(x.err));
    endtask

    // Advance one clock, then compare against the oldest scoreboard entry
    task automatic tick_check(input string tag);
        exp_t x;
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
        end else begin
            x = sb.pop_front();
            compare_outputs(tag, x);
        end
    endtask

    task automatic check_zero(input string tag);
        exp_t z;
        z.gnt = '0; z.src_en = '0; z.reg_en = '0; z.done = '0; z.busy = 1'b0; z.err = 1'b0;
        compare_outputs(tag, z);
    endtask

    task automatic idle(input string tag);
        push('0, '0, '0, '0, 1'b0, 1'b0);
        tick_check(tag);
    endtask

    // Full three-cycle transfer for requester w from register s to register d
    task automatic xfer(input string tag, input int w, input logic [3:0] s,
                        input logic [3:0] d, input bit churn);
        logic [15:0] re;
        logic        e;
        logic [3:0]  oh;
        oh = 4'(1) << w;
        re = 16'(1) << d;
        e  = 1'b0;
`ifdef BUS_ARB_R0_PROTECT_EN
        if (d == 4'd0) begin
            re = '0;
            e  = 1'b1;
        end
`endif
        push(oh, '0, '0, '0, 1'b1, 1'b0);
        push(oh, 16'(1) << s, re, '0, 1'b1, e);
        push('0, '0, '0, oh, 1'b1, 1'b0);
        tick_check({tag, "/gnt"});
        if (churn) begin
            src_sel = 16'($urandom);
            dst_sel = 16'($urandom);
            req     = '0;
        end
        tick_check({tag, "/xfer"});
        tick_check({tag, "/done"});
    endtask

    initial begin
        clear   = 1'b1;
        req     = '0;
        src_sel = '0;
        dst_sel = '0;
        #1;
        check_zero("reset_async");
        idle("reset_hold0");
        idle("reset_hold1");

        // Release with requests pending: arbitration on the first edge with clear low
        clear   = 1'b0;
        req     = 4'b1111;
        src_sel = pack(4'd1, 4'd2, 4'd3, 4'd4);
        dst_sel = pack(4'd8, 4'd9, 4'd10, 4'd11);
        xfer("rr0", 0, 4'd1, 4'd8, 1'b0);
        xfer("rr1", 1, 4'd2, 4'd9, 1'b0);
        xfer("rr2", 2, 4'd3, 4'd10, 1'b0);
        xfer("rr3", 3, 4'd4, 4'd11, 1'b0);
        xfer("rr4", 0, 4'd1, 4'd8, 1'b0);
        req = '0;
        idle("rr_idle");

        // Single transfer, requester 0 is the only one asking
        req     = 4'b0001;
        src_sel = pack(4'd3, 4'd12, 4'd13, 4'd14);
        dst_sel = pack(4'd5, 4'd1, 4'd2, 4'd3);
        xfer("single", 0, 4'd3, 4'd5, 1'b0);
        req = '0;
        idle("single_idle");

        // Source equals destination
        req     = 4'b0010;
        src_sel = pack(4'd0, 4'd7, 4'd0, 4'd0);
        dst_sel = pack(4'd0, 4'd7, 4'd0, 4'd0);
        xfer("same", 1, 4'd7, 4'd7, 1'b0);
        req = '0;
        idle("same_idle");

        // Inputs change and req drops right after the grant
        req     = 4'b0100;
        src_sel = pack(4'd0, 4'd0, 4'd9, 4'd0);
        dst_sel = pack(4'd0, 4'd0, 4'd12, 4'd0);
        xfer("churn", 2, 4'd9, 4'd12, 1'b1);
        idle("churn_idle");

        // Pointer now at 3: requester 3 beats requester 0, then 0 is served
        req     = 4'b1001;
        src_sel = pack(4'd5, 4'd0, 4'd0, 4'd6);
        dst_sel = pack(4'd13, 4'd0, 4'd0, 4'd14);
        xfer("wrap3", 3, 4'd6, 4'd14, 1'b0);
        xfer("wrap0", 0, 4'd5, 4'd13, 1'b0);
        req = '0;
        idle("wrap_idle");

        // Destination register 0
        req     = 4'b0001;
        src_sel = pack(4'd2, 4'd9, 4'd9, 4'd9);
        dst_sel = pack(4'd0, 4'd9, 4'd9, 4'd9);
        xfer("r0", 0, 4'd2, 4'd0, 1'b0);
        req = '0;
        idle("r0_idle");

        // Reset during XFER aborts the transfer
        req     = 4'b0100;
        src_sel = pack(4'd0, 4'd0, 4'd4, 4'd0);
        dst_sel = pack(4'd0, 4'd0, 4'd6, 4'd0);
        push(4'b0100, '0, '0, '0, 1'b1, 1'b0);
        tick_check("abort/gnt");
        clear = 1'b1;
        #1;
        check_zero("abort_async");
        idle("abort_hold");
        clear   = 1'b0;
        req     = 4'b0010;
        src_sel = pack(4'd0, 4'd11, 4'd0, 4'd0);
        dst_sel = pack(4'd0, 4'd15, 4'd0, 4'd0);
        xfer("post_abort", 1, 4'd11, 4'd15, 1'b0);
        req = '0;
        idle("final_idle");
        idle("final_idle2");

        cmp("sb_empty", 16'(sb.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
